alu_pipe: RTL and testbench

Parametrised, handshaked successor to the single-cycle accumulator ALU in the NES CPU datapath. It accepts one operation per valid/ready transfer and returns the result with full 6502-style N/Z/C/V flags plus a per-op flag-update mask. It adds optional BCD (decimal-mode) ADD/SUB as a two-cycle operation, with back-pressure from the register-file writeback stage. Throughput is one binary op per cycle.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_pipe_bcd_adjust.sv | 51 +++++
 rtl/alu_pipe.sv | 214 +++++++++++++++++++++
 tb/tb_alu_pipe.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined accumulator ALU.
//   - Opcode values (11 and 15+ are illegal).
//   - Flag bit positions inside the 4-bit {N,Z,C,V} flag/mask vectors.
//   - Handshake state encoding.
//   - pack_flags(): builds a flag vector in {N,Z,C,V} order.
package alu_pkg;

  localparam int unsigned OpAdd = 0;
  localparam int unsigned OpSub = 1;
  localparam int unsigned OpAnd = 2;
  localparam int unsigned OpOr  = 3;
  localparam int unsigned OpXor = 4;
  localparam int unsigned OpInc = 5;
  localparam int unsigned OpDec = 6;
  localparam int unsigned OpShr = 7;
  localparam int unsigned OpShl = 8;
  localparam int unsigned OpRtr = 9;
  localparam int unsigned OpRtl = 10;
  localparam int unsigned OpLd  = 12;
  localparam int unsigned OpCmp = 13;
  localparam int unsigned OpBit = 14;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  function automatic logic [3:0] pack_flags(input logic n, input logic z, input logic c,
                                            input logic v);
    return {n, z, c, v};
  endfunction

endpackage

// File: rtl/alu_pipe_bcd_adjust.sv
// bcd_adjust: combinational digit-serial BCD add/subtract.
//   a_i, b_i : operands, DIGITS nibbles each
//   sub_i    : 0 = add, 1 = subtract
//   cin_i    : 6502 carry in (for subtract, 1 = no borrow)
//   r_o      : adjusted result
//   cout_o   : final carry (for subtract, 1 = no final borrow)
// Invalid BCD digits go through the same rule without any error indication.
module bcd_adjust #(
  parameter int unsigned DIGITS = 2
) (
  input  logic [4*DIGITS-1:0] a_i,
  input  logic [4*DIGITS-1:0] b_i,
  input  logic                sub_i,
  input  logic                cin_i,
  output logic [4*DIGITS-1:0] r_o,
  output logic                cout_o
);

  logic       c;
  logic [5:0] s;

  always_comb begin
    // c is the running carry (add) or borrow (subtract)
    c   = sub_i ? ~cin_i : cin_i;
    s   = '0;
    r_o = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!sub_i) begin
        s = {2'b00, a_i[4*i+:4]} + {2'b00, b_i[4*i+:4]} + {5'b0, c};
        if (s > 6'd9) begin
          s = s + 6'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end else begin
        // 6-bit two's complement: bit 5 flags a negative digit difference
        s = {2'b00, a_i[4*i+:4]} - {2'b00, b_i[4*i+:4]} - {5'b0, c};
        if (s[5]) begin
          s = s - 6'd6;
          c = 1'b1;
        end else begin
          c = 1'b0;
        end
      end
      r_o[4*i+:4] = s[3:0];
    end
    cout_o = sub_i ? ~c : c;
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked accumulator ALU with 6502-style N/Z/C/V flags.
//   in_valid/in_ready      : op request handshake (op, operand1, operand2, carry, decimal)
//   out_valid/out_ready    : result handshake (result, flags, flag_mask, illegal)
// Binary ops complete one edge after acceptance; decimal ADD/SUB spend one extra
// cycle in StBusy running the BCD adjust. Outputs are registered and held under stall.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DECIMAL_EN = 1,
  parameter int unsigned OP_W       = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  input  logic             carry,
  input  logic             decimal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic [3:0]       flag_mask,
  output logic             illegal
);

  localparam int unsigned Msb = WIDTH - 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [3:0]       mask_q, mask_d;
  logic             illegal_q, illegal_d;
  // Operands parked for the decimal second cycle
  logic [WIDTH-1:0] dec_a_q, dec_a_d;
  logic [WIDTH-1:0] dec_b_q, dec_b_d;
  logic             dec_cin_q, dec_cin_d;
  logic             dec_sub_q, dec_sub_d;
  logic             dec_v_q, dec_v_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] bin_res;
  logic [3:0]       bin_flags, bin_mask;
  logic             bin_illegal;
  logic             n, z, c, v, nz_from_res;
  logic             dec_op, accept;
  logic [WIDTH-1:0] bcd_res;
  logic             bcd_cout;

  // Single-cycle binary datapath
  always_comb begin
    sum         = '0;
    bin_res     = '0;
    bin_mask    = 4'b0000;
    bin_illegal = 1'b0;
    n           = 1'b0;
    z           = 1'b0;
    c           = 1'b0;
    v           = 1'b0;
    nz_from_res = 1'b1;
    case (op)
      OP_W'(OpAdd): begin
        sum      = {1'b0, operand1} + {1'b0, operand2} + {{WIDTH{1'b0}}, carry};
        bin_res  = sum[WIDTH-1:0];
        c        = sum[WIDTH];
        v        = (operand1[Msb] == operand2[Msb]) && (sum[Msb] != operand1[Msb]);
        bin_mask = 4'b1111;
      end
      OP_W'(OpSub): begin
        sum      = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, carry};
        bin_res  = sum[WIDTH-1:0];
        c        = sum[WIDTH];
        v        = (operand1[Msb] != operand2[Msb]) && (sum[Msb] != operand1[Msb]);
        bin_mask = 4'b1111;
      end
      OP_W'(OpAnd): begin bin_res = operand1 & operand2;     bin_mask = 4'b1100; end
      OP_W'(OpOr):  begin bin_res = operand1 | operand2;     bin_mask = 4'b1100; end
      OP_W'(OpXor): begin bin_res = operand1 ^ operand2;     bin_mask = 4'b1100; end
      OP_W'(OpInc): begin bin_res = operand1 + WIDTH'(1);    bin_mask = 4'b1100; end
      OP_W'(OpDec): begin bin_res = operand1 - WIDTH'(1);    bin_mask = 4'b1100; end
      OP_W'(OpLd):  begin bin_res = operand1;                bin_mask = 4'b1100; end
      OP_W'(OpShr): begin
        bin_res = operand1 >> 1; c = operand1[0]; bin_mask = 4'b1110;
      end
      OP_W'(OpShl): begin
        bin_res = operand1 << 1; c = operand1[Msb]; bin_mask = 4'b1110;
      end
      OP_W'(OpRtr): begin
        bin_res = {carry, operand1[WIDTH-1:1]}; c = operand1[0]; bin_mask = 4'b1110;
      end
      OP_W'(OpRtl): begin
        bin_res = {operand1[WIDTH-2:0], carry}; c = operand1[Msb]; bin_mask = 4'b1110;
      end
      OP_W'(OpCmp): begin
        // N/Z come from the difference, the accumulator passes through
        sum         = {1'b0, operand1} + {1'b0, ~operand2} + {{WIDTH{1'b0}}, 1'b1};
        bin_res     = operand1;
        n           = sum[Msb];
        z           = (sum[WIDTH-1:0] == '0);
        c           = sum[WIDTH];
        nz_from_res = 1'b0;
        bin_mask    = 4'b1110;
      end
      OP_W'(OpBit): begin
        bin_res     = operand1;
        z           = ((operand1 & operand2) == '0);
        n           = operand2[Msb];
        v           = operand2[WIDTH-2];
        nz_from_res = 1'b0;
        bin_mask    = 4'b1101;
      end
      default: bin_illegal = 1'b1;
    endcase
    if (nz_from_res) begin
      n = bin_res[Msb];
      z = (bin_res == '0);
    end
    bin_flags = pack_flags(n, z, c, v) & bin_mask;
  end

  bcd_adjust #(
    .DIGITS(WIDTH / 4)
  ) u_bcd_adjust (
    .a_i   (dec_a_q),
    .b_i   (dec_b_q),
    .sub_i (dec_sub_q),
    .cin_i (dec_cin_q),
    .r_o   (bcd_res),
    .cout_o(bcd_cout)
  );

  always_comb begin
    in_ready  = (state_q == StEmpty) || ((state_q == StFull) && out_ready);
    accept    = in_valid && in_ready;
    dec_op    = (DECIMAL_EN != 0) && decimal &&
                ((op == OP_W'(OpAdd)) || (op == OP_W'(OpSub)));
    state_d   = state_q;
    result_d  = result_q;
    flags_d   = flags_q;
    mask_d    = mask_q;
    illegal_d = illegal_q;
    dec_a_d   = dec_a_q;
    dec_b_d   = dec_b_q;
    dec_cin_d = dec_cin_q;
    dec_sub_d = dec_sub_q;
    dec_v_d   = dec_v_q;

    if ((state_q == StFull) && out_ready) begin
      state_d = StEmpty;
    end

    if (state_q == StBusy) begin
      // V was captured from the binary op at acceptance
      state_d   = StFull;
      result_d  = bcd_res;
      flags_d   = pack_flags(bcd_res[Msb], bcd_res == '0, bcd_cout, dec_v_q);
      mask_d    = 4'b1111;
      illegal_d = 1'b0;
    end

    if (accept) begin
      if (dec_op) begin
        state_d   = StBusy;
        dec_a_d   = operand1;
        dec_b_d   = operand2;
        dec_cin_d = carry;
        dec_sub_d = (op == OP_W'(OpSub));
        dec_v_d   = bin_flags[0];
      end else begin
        state_d   = StFull;
        result_d  = bin_res;
        flags_d   = bin_flags;
        mask_d    = bin_mask;
        illegal_d = bin_illegal;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StEmpty;
      result_q  <= '0;
      flags_q   <= '0;
      mask_q    <= '0;
      illegal_q <= 1'b0;
      dec_a_q   <= '0;
      dec_b_q   <= '0;
      dec_cin_q <= 1'b0;
      dec_sub_q <= 1'b0;
      dec_v_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      mask_q    <= mask_d;
      illegal_q <= illegal_d;
      dec_a_q   <= dec_a_d;
      dec_b_q   <= dec_b_d;
      dec_cin_q <= dec_cin_d;
      dec_sub_q <= dec_sub_d;
      dec_v_q   <= dec_v_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign result    = result_q;
  assign flags     = flags_q;
  assign flag_mask = mask_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=8, decimal enabled).
// The driver pushes the reference model's answer when an op is accepted; the
// monitor pops and compares whenever the DUT presents a result.
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W   = 8;
  localparam int OPW = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [OPW-1:0] op = '0;
  logic [W-1:0]   operand1 = '0;
  logic [W-1:0]   operand2 = '0;
  logic           carry = 1'b0;
  logic           decimal = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [W-1:0]   result;
  logic [3:0]     flags;
  logic [3:0]     flag_mask;
  logic           illegal;

  alu_pipe #(
    .WIDTH     (W),
    .DECIMAL_EN(1),
    .OP_W      (OPW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .operand1 (operand1),
    .operand2 (operand2),
    .carry    (carry),
    .decimal  (decimal),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .flags    (flags),
    .flag_mask(flag_mask),
    .illegal  (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int r;
    int f;
    int m;
    int ill;
    int lat;
    int acc;
  } exp_t;

  exp_t exp_q[$];
  exp_t head;
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  bit   seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int from_bcd(input int x);
    int val = 0;
    int p = 1;
    for (int i = 0; i < W / 4; i++) begin
      val += ((x >> (4 * i)) & 15) * p;
      p *= 10;
    end
    return val;
  endfunction

  function automatic int to_bcd(input int x);
    int val = 0;
    int y = x;
    for (int i = 0; i < W / 4; i++) begin
      val |= (y % 10) << (4 * i);
      y /= 10;
    end
    return val;
  endfunction

  // Reference model: plain integer arithmetic on operand values
  function automatic exp_t model(input int o, input int a, input int b, input int cin,
                                 input int dec);
    exp_t e;
    int m_mod = 1 << W;
    int h = 1 << (W - 1);
    int sa = (a >= h) ? a - m_mod : a;
    int sb = (b >= h) ? b - m_mod : b;
    int r = 0, n = 0, z = 0, c = 0, v = 0, m = 0, ill = 0, s = 0, p = 1;
    bit nz = 1'b1;
    bit isdec = (dec != 0) && (o == int'(OpAdd) || o == int'(OpSub));
    for (int i = 0; i < W / 4; i++) p *= 10;
    case (o)
      OpAdd: begin
        s = sa + sb + cin; v = (s > h - 1 || s < -h) ? 1 : 0; m = 15;
        if (isdec) begin
          s = from_bcd(a) + from_bcd(b) + cin; c = (s >= p) ? 1 : 0; r = to_bcd(s % p);
        end else begin
          s = a + b + cin; c = (s >= m_mod) ? 1 : 0; r = s % m_mod;
        end
      end
      OpSub: begin
        s = sa - sb - (1 - cin); v = (s > h - 1 || s < -h) ? 1 : 0; m = 15;
        if (isdec) begin
          s = from_bcd(a) - from_bcd(b) - (1 - cin); c = (s >= 0) ? 1 : 0;
          r = to_bcd((s + p) % p);
        end else begin
          s = a - b - (1 - cin); c = (s >= 0) ? 1 : 0; r = (s + m_mod) % m_mod;
        end
      end
      OpAnd: begin r = a & b; m = 12; end
      OpOr:  begin r = a | b; m = 12; end
      OpXor: begin r = a ^ b; m = 12; end
      OpInc: begin r = (a + 1) % m_mod; m = 12; end
      OpDec: begin r = (a + m_mod - 1) % m_mod; m = 12; end
      OpLd:  begin r = a; m = 12; end
      OpShr: begin r = a / 2; c = a % 2; m = 14; end
      OpShl: begin r = (a * 2) % m_mod; c = (a >= h) ? 1 : 0; m = 14; end
      OpRtr: begin r = cin * h + a / 2; c = a % 2; m = 14; end
      OpRtl: begin r = (a * 2) % m_mod + cin; c = (a >= h) ? 1 : 0; m = 14; end
      OpCmp: begin
        r = a; n = (((a - b + m_mod) % m_mod) >= h) ? 1 : 0; z = (a == b) ? 1 : 0;
        c = (a >= b) ? 1 : 0; m = 14; nz = 1'b0;
      end
      OpBit: begin
        r = a; z = ((a & b) == 0) ? 1 : 0; n = (b >= h) ? 1 : 0; v = (b / (h / 2)) % 2;
        m = 13; nz = 1'b0;
      end
      default: ill = 1;
    endcase
    if (nz) begin
      n = (r >= h) ? 1 : 0;
      z = (r == 0) ? 1 : 0;
    end
    e.r   = r;
    e.f   = ((n << 3) | (z << 2) | (c << 1) | v) & m;
    e.m   = m;
    e.ill = ill;
    e.lat = isdec ? 2 : 1;
    e.acc = 0;
    return e;
  endfunction

  task automatic issue(input int o, input int a, input int b, input int cin, input int dec,
                       output int waits);
    exp_t e;
    op       = OPW'(o);
    operand1 = W'(a);
    operand2 = W'(b);
    carry    = cin[0];
    decimal  = dec[0];
    in_valid = 1'b1;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    e     = model(o, a, b, cin, dec);
    e.acc = cyc;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'b0;
      else if (ready_mode == 1) out_ready = 1'b1;
      else out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency, result fields, stall behaviour, unexpected outputs
  always @(negedge clk) begin
    int age;
    if (reset) begin
      seen = 1'b0;
    end else if (exp_q.size() > 0) begin
      head = exp_q[0];
      age  = cyc - head.acc;
      if (head.lat == 2 && age == 1) begin
        check("busy_in_ready", in_ready, 0);
        check("busy_out_valid", out_valid, 0);
      end
      if (out_valid) begin
        if (!seen) begin
          check("latency", age, head.lat);
          seen = 1'b1;
        end
        check("result", result, head.r);
        check("flags", flags, head.f);
        check("flag_mask", flag_mask, head.m);
        check("illegal", illegal, head.ill);
        if (out_ready) begin
          void'(exp_q.pop_front());
          seen = 1'b0;
        end else begin
          check("stall_in_ready", in_ready, 0);
        end
      end else if (age >= head.lat) begin
        check("out_valid_due", out_valid, 1);
      end
    end else begin
      check("unexpected_out_valid", out_valid, 0);
    end
  end

  initial begin
    int waits;
    int o, a, b, cin, dec, t;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", flags, 0);
    check("rst_mask", flag_mask, 0);
    check("rst_illegal", illegal, 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases
    issue(OpAdd, 8'h50, 8'h50, 0, 0, waits);
    issue(OpSub, 8'h00, 8'h01, 1, 0, waits);
    issue(OpCmp, 8'h10, 8'h10, 0, 0, waits);
    issue(OpAdd, 8'h58, 8'h46, 1, 1, waits);
    issue(OpSub, 8'h46, 8'h12, 1, 1, waits);
    issue(OpRtr, 8'h01, 8'h00, 1, 0, waits);
    issue(OpBit, 8'h0F, 8'hC0, 0, 0, waits);
    issue(11, 8'h33, 8'h44, 1, 0, waits);
    repeat (4) @(posedge clk);
    #1;

    // Back-pressure then back-to-back
    ready_mode = 0;
    @(posedge clk);
    #2;
    issue(OpXor, 8'hA5, 8'h3C, 0, 0, waits);
    repeat (3) @(negedge clk);
    ready_mode = 1;
    @(posedge clk);
    #2;
    issue(OpInc, 8'hFF, 8'h00, 0, 0, waits);
    check("b2b_wait0", waits, 0);
    issue(OpShl, 8'h81, 8'h00, 0, 0, waits);
    check("b2b_wait1", waits, 0);
    issue(OpDec, 8'h00, 8'h00, 0, 0, waits);
    check("b2b_wait2", waits, 0);
    issue(OpAnd, 8'hF0, 8'h0F, 0, 0, waits);
    check("b2b_wait3", waits, 0);
    repeat (4) @(posedge clk);
    #1;

    // Reset while the decimal op is in its busy cycle
    issue(OpAdd, 8'h12, 8'h34, 0, 1, waits);
    #1;
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    check("midrst_flags", flags, 0);
    check("midrst_mask", flag_mask, 0);
    check("midrst_illegal", illegal, 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(negedge clk);
    check("postrst_in_ready", in_ready, 1);
    repeat (3) begin
      @(negedge clk);
      check("postrst_no_stale", out_valid, 0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure
    ready_mode = 2;
    for (int i = 0; i < 300; i++) begin
      o   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 31))
                                        : int'($urandom_range(0, 15));
      dec = int'($urandom_range(0, 1));
      cin = int'($urandom_range(0, 1));
      if (dec != 0 && (o == int'(OpAdd) || o == int'(OpSub))) begin
        a = to_bcd(int'($urandom_range(0, 99)));
        b = to_bcd(int'($urandom_range(0, 99)));
      end else begin
        a = int'($urandom_range(0, 255));
        b = int'($urandom_range(0, 255));
      end
      issue(o, a, b, cin, dec, waits);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end

    ready_mode = 1;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
